// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and scan-code constants.
// Also used by the paddle controller for its key map.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_I = 8'h43;
  localparam logic [7:0] KEY_K = 8'h42;

endpackage

// File: rtl/ps2_rx_if.sv
// PS/2 pins plus decoded scan-code strobes.
// slave: the receiver; master: pins driver / code consumer.
interface ps2_rx_if;

  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       frame_err;

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output scan_code,
    output scan_ready,
    output frame_err
  );

  modport master (
    output ps2_clk,
    output ps2_data,
    input  scan_code,
    input  scan_ready,
    input  frame_err
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// Synchronises PS/2 clock/data, deglitches the clock
// and emits a one-cycle strobe on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic sdata
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    csync;
  logic [1:0]    dsync;
  logic          fclk;
  logic [CW-1:0] cnt;

  assign sdata = dsync[1];

  // two-flop synchronisers, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csync <= 2'b11;
      dsync <= 2'b11;
    end else begin
      csync <= {csync[0], ps2_clk};
      dsync <= {dsync[0], ps2_data};
    end
  end

  // fclk follows the pin only after FILTER_LEN equal samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fclk <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (csync[1] == fclk) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt  <= '0;
        fclk <= csync[1];
        fall <= ~csync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with parity/stop check and watchdog.
// Optional break/extended-code suppression: define PS2_BREAK_FILTER_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     rst_n,
  ps2_rx_if.slave  bus
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES);

  logic          fall;
  logic          sdata;
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [WW-1:0] wd;
  logic          timeout;
  logic          accept;
  logic          err;
  logic          strobe;
  logic [7:0]    code_q;
  logic          ready_q;
  logic          err_q;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_clk (bus.ps2_clk),
    .ps2_data(bus.ps2_data),
    .fall    (fall),
    .sdata   (sdata)
  );

  assign timeout = (state != IDLE) && (wd == WD_MAX);

  // frame state and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      par     <= par_n;
    end
  end

  // next-state, bit capture and frame verdict
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par;
    accept    = 1'b0;
    err       = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      err     = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!sdata) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shift_n   = {sdata, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = sdata;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (sdata && ^{shift, par}) accept = 1'b1;
          else                        err    = 1'b1;
        end
      endcase
    end
  end

  // watchdog: cleared by edges and in IDLE, saturates at limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (fall || state == IDLE) begin
      wd <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pend;

  assign strobe = accept && !break_pend &&
                  shift != SC_BREAK && shift != SC_EXT;

  // remembers an F0 prefix so the following release code is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      break_pend <= 1'b0;
    end else if (err) begin
      break_pend <= 1'b0;
    end else if (accept) begin
      if (shift == SC_BREAK)   break_pend <= 1'b1;
      else if (shift != SC_EXT) break_pend <= 1'b0;
    end
  end
`else
  assign strobe = accept;
`endif

  // registered outputs: one cycle after the stop-bit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= strobe;
      err_q   <= err;
      if (accept) code_q <= shift;
    end
  end

  assign bus.scan_code  = code_q;
  assign bus.scan_ready = ready_q;
  assign bus.frame_err  = err_q;

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receives the PS/2 keyboard serial stream (device-to-host only) and turns each valid 11-bit frame into an 8-bit set-2 scan code with a one-cycle `scan_ready` strobe. It sits between the keyboard pins and the paddle controller, and feeds that controller's `scan_code`/`scan_ready` inputs directly. The block synchronises and deglitches the external clock and data lines, checks parity and stop bits, and recovers from stalled frames with a watchdog.

## Interface
- `FILTER_LEN`, 4: consecutive equal samples required before the filtered ps2_clk changes; range 2..16.
- `TIMEOUT_CYCLES`, 50000: watchdog limit in clk cycles without a falling edge while mid-frame (2 ms at 25 MHz); range ≥ 64.
- `clk` input 1: system clock; one clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw keyboard clock pin, asynchronous.
- `ps2_data` input 1: raw keyboard data pin, asynchronous.
- `scan_code` output 8: last accepted byte; holds its value between strobes.
- `scan_ready` output 1: one-cycle pulse; `scan_code` is valid in the same cycle.
- `frame_err` output 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- Input conditioning: `ps2_clk` and `ps2_data` each pass through 2-flop synchronisers. The filtered clock `fclk` resets to 1. `fclk` takes the synchronised clock value only after `FILTER_LEN` consecutive identical samples.
- Edge detect: internal strobe `fall` pulses for one cycle when `fclk` goes 1→0. Data is sampled from the synchronised data line in the `fall` cycle.
- State machine states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall`, sampled data 0 (start bit) → DATA with bit counter 0. Sampled data 1 → stay in IDLE, no error.
  - DATA: on each `fall`, shift the bit in LSB first and increment the counter. The 8th bit → PARITY.
  - PARITY: on `fall`, store the parity bit → STOP.
  - STOP: on `fall`, go to IDLE. If stop bit = 1 and the 9 bits (data plus parity) have odd parity, the frame is accepted; otherwise `frame_err` pulses.
- Watchdog: a counter clears on every `fall` and in IDLE, and counts otherwise. When it reaches `TIMEOUT_CYCLES`: go to IDLE, pulse `frame_err`, discard the partial byte. The counter saturates so it cannot wrap.
- On acceptance, `scan_code` loads the byte. `scan_ready` pulses unless the byte is suppressed (see Configuration).
- Reset (asynchronous, at any point, including mid-frame):
  - state IDLE, counters 0, `fclk` = 1, synchronisers 1;
  - `scan_code` = 8'h00, `scan_ready` = 0, `frame_err` = 0.
- `scan_ready` and `frame_err` are never asserted in the same cycle.

## Timing
- A raw pin fall held stable produces `fall` exactly 2 + `FILTER_LEN` cycles later.
- `scan_ready` / `frame_err` are registered: they assert in the cycle after the stop-bit `fall`.
- The minimum spacing between strobes is one frame (~11 PS/2 clocks). No back-pressure is needed and none is offered.
- Glitches on ps2_clk shorter than `FILTER_LEN` cycles produce no `fall`.

## Configuration
- `PS2_BREAK_FILTER_EN` defined:
  - An accepted 8'hF0 sets `break_pend` and is not strobed.
  - The next accepted byte is not strobed and clears `break_pend`.
  - An accepted 8'hE0 is never strobed and leaves `break_pend` unchanged.
  - `frame_err` clears `break_pend`.
  - Only make codes reach the paddle controller, so key release no longer moves a paddle.
- Not defined: every accepted byte, including F0/E0, pulses `scan_ready`. No `break_pend` register exists.
- `scan_code` updates on every accepted byte in both modes.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - `SC_BREAK` = 8'hF0 and `SC_EXT` = 8'hE0;
  - the shared key constants W = 8'h1D, S = 8'h1B, I = 8'h43, K = 8'h42, which the paddle controller also uses.
- Sub-module `ps2_clk_filter` contains the synchroniser, the `FILTER_LEN` filter and the `fall` strobe generator. The frame state machine, parity check, watchdog and break filter stay in `ps2_rx`.

## Test plan
- Valid frame for 8'h1D (PS/2 clock ~12.5 kHz) → one `scan_ready` pulse with `scan_code` = 8'h1D in that cycle; `frame_err` stays 0.
- Frame for 8'h43 with parity flipped → `frame_err` pulses once, no `scan_ready`, `scan_code` keeps its previous value. Stop bit 0 on a valid 8'h42 frame → same response.
- Stop ps2_clk after 5 data bits for `TIMEOUT_CYCLES` + 10 cycles → one `frame_err`, state returns to IDLE; a following valid 8'h1B frame gives `scan_code` = 8'h1B.
- 2-cycle low glitches on ps2_clk (with `FILTER_LEN` = 4), both in IDLE and mid-frame → no state change; a valid 8'h1D frame still decodes.
- With `PS2_BREAK_FILTER_EN` defined: sequence 1D, F0, 1D, E0, 1B → `scan_ready` pulses for 1D and 1B only. Without the macro: 5 pulses.
- Assert `rst_n` mid-frame after 4 data bits, then release → outputs reset; the next complete 8'h42 frame decodes correctly.
